ram_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 2^16 x 32 RAM (RAM_2_16x32). Port 0 (instruction fetch) and port 1 (load/store unit) each issue single-word read or write requests; the block selects one round-robin, drives the RAM's level-sensitive write_enable/read_enable/address/data_input for exactly one cycle, captures data_output, and returns a completion pulse to the winner. It sits between the CPU front-end/back-end and the RAM instance and is the only driver of the RAM's inputs.

---
 rtl/ram_port_arbiter.sv | 134 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Two-requester round-robin arbiter and sequencer for the shared 2^16 x 32
//   RAM. It is the only driver of the RAM inputs. Each access takes three
//   cycles: an IDLE cycle to accept a request, one ACCESS cycle with the RAM
//   enable asserted, and one COMPLETE cycle that pulses done to the winner.
//
//   Ports
//     clk, rst_n               clock, asynchronous active-low reset
//     req0/1, we0/1            request and write flag per port (held until gnt)
//     addr0/1, wdata0/1        word address and write data per port
//     gnt0/1                   one-cycle pulse: request accepted
//     done0/1                  one-cycle pulse: access complete
//     rdata0/1                 read data, held until the port's next read
//     busy                     high in any state other than IDLE
//     ram_write_enable         to RAM write_enable (ACCESS only)
//     ram_read_enable          to RAM read_enable  (ACCESS only)
//     ram_address              to RAM address, holds between accesses
//     ram_data_input           to RAM data_input, holds between writes
//     ram_data_output          from RAM data_output (combinational read)
module ram_port_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic              ram_write_enable,
   output logic              ram_read_enable,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_input,
   input  logic [DATA_W-1:0] ram_data_output
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              prio;       // port favoured when both request
   logic              winner;     // port owning the current access
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              accept;
   logic              pick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Outputs decode only from state and latched registers; request inputs
   // influence nothing but the accept/pick terms feeding registers.
   always_comb begin
      state_nxt        = state;
      accept           = 1'b0;
      pick             = (req0 && req1) ? prio : req1;
      gnt0             = 1'b0;
      gnt1             = 1'b0;
      done0            = 1'b0;
      done1            = 1'b0;
      ram_write_enable = 1'b0;
      ram_read_enable  = 1'b0;
      busy             = (state != IDLE);
      ram_address      = lat_addr;
      ram_data_input   = lat_wdata;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               accept    = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            gnt0             = ~winner;
            gnt1             = winner;
            ram_write_enable = lat_we;
            ram_read_enable  = ~lat_we;
            state_nxt        = COMPLETE;
         end
         COMPLETE: begin
            done0     = ~winner;
            done1     = winner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // lat_wdata is loaded only on write acceptance so ram_data_input keeps its
   // last written value across reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio      <= 1'b0;
         winner    <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         if (accept) begin
            winner   <= pick;
            prio     <= ~pick;
            lat_we   <= pick ? we1 : we0;
            lat_addr <= pick ? addr1 : addr0;
            if (pick ? we1 : we0)
               lat_wdata <= pick ? wdata1 : wdata0;
         end
         if (state == ACCESS && !lat_we) begin
            if (winner) rdata1 <= ram_data_output;
            else        rdata0 <= ram_data_output;
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Directed bench for ram_port_arbiter with a behavioural 2^16 x 32 RAM
//   (combinational read, write on rising edge while write_enable is high).
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, done0, done1, busy;
   logic [31:0] rdata0, rdata1;
   logic        ram_write_enable, ram_read_enable;
   logic [15:0] ram_address;
   logic [31:0] ram_data_input, ram_data_output;

   logic [31:0] mem [0:65535];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   assign ram_data_output = mem[ram_address];
   always @(posedge clk)
      if (ram_write_enable) mem[ram_address] <= ram_data_input;

   ram_port_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
      .ram_address(ram_address), .ram_data_input(ram_data_input),
      .ram_data_output(ram_data_output)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete access from a single port, starting one time unit after an
   // edge with the DUT in IDLE; ends in the same phase back in IDLE.
   task automatic access(input int port, input logic we, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd);
      if (port == 0) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wdata; end
      else           begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wdata; end
      tick();
      check("gnt0", {31'd0, gnt0}, {31'd0, port == 0});
      check("gnt1", {31'd0, gnt1}, {31'd0, port == 1});
      check("wen_acc", {31'd0, ram_write_enable}, {31'd0, we});
      check("ren_acc", {31'd0, ram_read_enable}, {31'd0, !we});
      check("addr_acc", {16'd0, ram_address}, {16'd0, addr});
      if (we) check("din_acc", ram_data_input, wdata);
      req0 = 0; req1 = 0;
      tick();
      check("done0", {31'd0, done0}, {31'd0, port == 0});
      check("done1", {31'd0, done1}, {31'd0, port == 1});
      check("en_cpl", {30'd0, ram_write_enable, ram_read_enable}, 32'd0);
      check("busy_cpl", {31'd0, busy}, 32'd1);
      if (!we) check("rdata", (port == 0) ? rdata0 : rdata1, exp_rd);
      tick();
      check("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      tick();
   endtask

   initial begin
      rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_gnt_done", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
      check("rst_en", {30'd0, ram_write_enable, ram_read_enable}, 32'd0);
      check("rst_addr", {16'd0, ram_address}, 32'd0);
      check("rst_din", ram_data_input, 32'd0);
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);
      tick();
      rst_n = 1;
      tick();

      // Port 0 write then read of address 66.
      access(0, 1'b1, 16'd66, 32'd20, 32'd0);
      access(0, 1'b0, 16'd66, 32'd0, 32'd20);

      // Port 1 writes 55, port 0 reads it; rdata1 untouched.
      access(1, 1'b1, 16'd55, 32'd1, 32'd0);
      access(0, 1'b0, 16'd55, 32'd0, 32'd1);
      check("rdata1_keep", rdata1, 32'd0);

      // Address extremes.
      access(1, 1'b1, 16'hFFFF, 32'hA5A5_0001, 32'd0);
      access(1, 1'b1, 16'h0000, 32'h5A5A_0002, 32'd0);
      access(0, 1'b0, 16'hFFFF, 32'd0, 32'hA5A5_0001);
      access(1, 1'b0, 16'h0000, 32'd0, 32'h5A5A_0002);

      // Simultaneous requests after reset: port 0 first, then port 1.
      do_reset();
      req0 = 1; we0 = 0; addr0 = 16'd66;
      req1 = 1; we1 = 0; addr1 = 16'd55;
      tick();
      check("sim_gnt", {30'd0, gnt0, gnt1}, 32'd2);
      check("sim_addr0", {16'd0, ram_address}, 32'd66);
      req0 = 0;
      tick();
      check("sim_done0", {30'd0, done0, done1}, 32'd2);
      check("sim_rdata0", rdata0, 32'd20);
      tick();
      check("sim_idle", {31'd0, busy}, 32'd0);
      tick();
      check("sim_gnt1", {30'd0, gnt0, gnt1}, 32'd1);
      check("sim_addr1", {16'd0, ram_address}, 32'd55);
      req1 = 0;
      tick();
      check("sim_done1", {30'd0, done0, done1}, 32'd1);
      check("sim_rdata1", rdata1, 32'd1);
      tick();

      // Both held for eight accesses: strict alternation starting at port 0.
      req0 = 1; we0 = 0; addr0 = 16'd66;
      req1 = 1; we1 = 0; addr1 = 16'd55;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("rr_gnt", {30'd0, gnt0, gnt1}, (i % 2 == 0) ? 32'd2 : 32'd1);
         check("rr_excl", {31'd0, ram_write_enable & ram_read_enable}, 32'd0);
         check("rr_busy_acc", {31'd0, busy}, 32'd1);
         tick();
         check("rr_done", {30'd0, done0, done1}, (i % 2 == 0) ? 32'd2 : 32'd1);
         check("rr_rdata", (i % 2 == 0) ? rdata0 : rdata1, (i % 2 == 0) ? 32'd20 : 32'd1);
         tick();
         check("rr_busy_idle", {31'd0, busy}, 32'd0);
      end
      req0 = 0; req1 = 0;
      tick();
      check("rr_stop", {31'd0, busy}, 32'd0);

      // Reset during a write's ACCESS cycle.
      access(0, 1'b1, 16'd77, 32'h0000_1234, 32'd0);
      req0 = 1; we0 = 1; addr0 = 16'd77; wdata0 = 32'hDEAD_BEEF;
      tick();
      check("rw_wen", {31'd0, ram_write_enable}, 32'd1);
      #2;
      rst_n = 0;
      #1;
      check("rw_en_drop", {30'd0, ram_write_enable, ram_read_enable}, 32'd0);
      check("rw_gnt_done", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
      check("rw_busy", {31'd0, busy}, 32'd0);
      check("rw_addr", {16'd0, ram_address}, 32'd0);
      check("rw_din", ram_data_input, 32'd0);
      check("rw_rdata0", rdata0, 32'd0);
      req0 = 0;
      tick();
      check("rw_no_done", {30'd0, done0, done1}, 32'd0);
      rst_n = 1;
      tick();
      check("rw_no_done2", {30'd0, done0, done1}, 32'd0);
      access(0, 1'b0, 16'd77, 32'd0, 32'h0000_1234);

      // Address change during ACCESS is ignored.
      req0 = 1; we0 = 0; addr0 = 16'd66;
      tick();
      check("hold_addr_a", {16'd0, ram_address}, 32'd66);
      addr0 = 16'd55; we0 = 1;
      #4;
      check("hold_addr_b", {16'd0, ram_address}, 32'd66);
      check("hold_ren", {30'd0, ram_write_enable, ram_read_enable}, 32'd1);
      req0 = 0;
      tick();
      check("hold_done", {31'd0, done0}, 32'd1);
      check("hold_addr_c", {16'd0, ram_address}, 32'd66);
      check("hold_rdata", rdata0, 32'd20);
      tick();
      check("hold_idle", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
